// File: rtl/game_pkg.sv
// Shared game types: player headings, FSM states, grid cells.
// Cell coordinates are wide signed values so a step off the grid stays visible.
package game_pkg;

  typedef enum logic [2:0] {
    WAIT,
    RIGHT,
    DOWN,
    LEFT,
    UP
  } directions;

  localparam int GRID_W_DEF = 64;
  localparam int GRID_H_DEF = 48;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER
  } game_state_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } cell_pos_t;

  function automatic cell_pos_t step_cell(
    cell_pos_t p,
    directions d
  );
    cell_pos_t n;
    n = p;
    case (d)
      RIGHT:   n.x = p.x + 16'sd1;
      LEFT:    n.x = p.x - 16'sd1;
      DOWN:    n.y = p.y + 16'sd1;
      UP:      n.y = p.y - 16'sd1;
      default: n = p;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/player_position_ctrl_if.sv
// Direction inputs and head position / crash status outputs.
// master drives headings and game_active; slave is the position controller.
interface player_position_ctrl_if #(
  parameter int XW = 6,
  parameter int YW = 6
);
  import game_pkg::*;

  logic          game_active;
  directions     direction_1;
  directions     direction_2;
  logic [XW-1:0] x1;
  logic [YW-1:0] y1;
  logic [XW-1:0] x2;
  logic [YW-1:0] y2;
  logic          move_strobe;
  logic          crash_1;
  logic          crash_2;
  logic          game_over;

  modport master (
    output game_active, direction_1, direction_2,
    input  x1, y1, x2, y2,
    input  move_strobe, crash_1, crash_2, game_over
  );

  modport slave (
    input  game_active, direction_1, direction_2,
    output x1, y1, x2, y2,
    output move_strobe, crash_1, crash_2, game_over
  );

endinterface

// File: rtl/move_tick_gen.sv
// Move tick: one-cycle pulse every TICK_DIV cycles while enabled.
// Counter is held at zero whenever enable is low.
module move_tick_gen #(
  parameter int TICK_DIV = 1625000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/player_position_ctrl.sv
// Two-player head stepper with wall / head-on / contact crash detection.
// Define PLAYER_POSITION_WRAP_EN to wrap at grid edges instead of crashing.
module player_position_ctrl
  import game_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int TICK_DIV = 1625000,
  parameter int START_X1 = 16,
  parameter int START_Y1 = 24,
  parameter int START_X2 = 47,
  parameter int START_Y2 = 24
) (
  input  logic clk,
  input  logic rst,
  player_position_ctrl_if.slave bus
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] SX1 = XW'(START_X1);
  localparam logic [YW-1:0] SY1 = YW'(START_Y1);
  localparam logic [XW-1:0] SX2 = XW'(START_X2);
  localparam logic [YW-1:0] SY2 = YW'(START_Y2);

  game_state_t   state, state_n;
  logic [XW-1:0] x1_q, x1_n, x2_q, x2_n;
  logic [YW-1:0] y1_q, y1_n, y2_q, y2_n;
  logic          strobe_q, strobe_n;
  logic          c1_q, c1_n, c2_q, c2_n;
  logic          go_q, go_n;
  logic          tick, to_start;
  cell_pos_t     cur1, cur2, cand1, cand2;
  logic          mv1, mv2, wall1, wall2;
  logic          head, hit1, hit2, k1, k2;

`ifdef PLAYER_POSITION_WRAP_EN
  function automatic cell_pos_t fold(cell_pos_t p);
    cell_pos_t n;
    n = p;
    if (p.x < 16'sd0)               n.x = 16'(GRID_W - 1);
    else if (p.x >= 16'(GRID_W))    n.x = 16'sd0;
    if (p.y < 16'sd0)               n.y = 16'(GRID_H - 1);
    else if (p.y >= 16'(GRID_H))    n.y = 16'sd0;
    return n;
  endfunction

  function automatic logic off_grid(cell_pos_t p);
    return (p.x != p.x);
  endfunction
`else
  function automatic cell_pos_t fold(cell_pos_t p);
    return p;
  endfunction

  function automatic logic off_grid(cell_pos_t p);
    return (p.x < 16'sd0) || (p.x >= 16'(GRID_W)) ||
           (p.y < 16'sd0) || (p.y >= 16'(GRID_H));
  endfunction
`endif

  move_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (state == RUN),
    .tick   (tick)
  );

  always_comb begin
    cur1  = '{x: 16'(x1_q), y: 16'(y1_q)};
    cur2  = '{x: 16'(x2_q), y: 16'(y2_q)};
    mv1   = bus.direction_1 != WAIT;
    mv2   = bus.direction_2 != WAIT;
    cand1 = fold(step_cell(cur1, bus.direction_1));
    cand2 = fold(step_cell(cur2, bus.direction_2));
    wall1 = mv1 && off_grid(cand1);
    wall2 = mv2 && off_grid(cand2);
    head  = mv1 && mv2 && (cand1 == cand2);
    // A stationary player is a solid obstacle for the mover
    hit1  = mv1 && !mv2 && (cand1 == cur2);
    hit2  = mv2 && !mv1 && (cand2 == cur1);
    k1    = wall1 || head || hit1;
    k2    = wall2 || head || hit2;
  end

  always_comb begin
    state_n  = state;
    x1_n     = x1_q;
    y1_n     = y1_q;
    x2_n     = x2_q;
    y2_n     = y2_q;
    strobe_n = 1'b0;
    c1_n     = c1_q;
    c2_n     = c2_q;
    go_n     = go_q;
    to_start = 1'b0;
    unique case (state)
      IDLE: begin
        to_start = 1'b1;
        if (bus.game_active) state_n = RUN;
      end
      RUN: begin
        if (!bus.game_active) begin
          state_n  = IDLE;
          to_start = 1'b1;
        end else if (tick) begin
          strobe_n = 1'b1;
          if (!k1) begin
            x1_n = cand1.x[XW-1:0];
            y1_n = cand1.y[YW-1:0];
          end
          if (!k2) begin
            x2_n = cand2.x[XW-1:0];
            y2_n = cand2.y[YW-1:0];
          end
          c1_n = k1;
          c2_n = k2;
          go_n = k1 || k2;
          if (k1 || k2) state_n = OVER;
        end
      end
      OVER: begin
        if (!bus.game_active) begin
          state_n  = IDLE;
          to_start = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (to_start) begin
      x1_n = SX1;
      y1_n = SY1;
      x2_n = SX2;
      y2_n = SY2;
      c1_n = 1'b0;
      c2_n = 1'b0;
      go_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x1_q     <= SX1;
      y1_q     <= SY1;
      x2_q     <= SX2;
      y2_q     <= SY2;
      strobe_q <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state    <= state_n;
      x1_q     <= x1_n;
      y1_q     <= y1_n;
      x2_q     <= x2_n;
      y2_q     <= y2_n;
      strobe_q <= strobe_n;
      c1_q     <= c1_n;
      c2_q     <= c2_n;
      go_q     <= go_n;
    end
  end

  assign bus.x1          = x1_q;
  assign bus.y1          = y1_q;
  assign bus.x2          = x2_q;
  assign bus.y2          = y2_q;
  assign bus.move_strobe = strobe_q;
  assign bus.crash_1     = c1_q;
  assign bus.crash_2     = c2_q;
  assign bus.game_over   = go_q;

endmodule

// File: doc/player_position_ctrl.md
Name: player_position_ctrl

Overview:
- Downstream of the direction FSM: consumes `direction_1` and `direction_2`, and steps each player's head one grid cell per game tick.
- Detects wall and head-on/body-contact crashes, and latches game over.
- Feeds the renderer (cell coordinates) and the score/game-state logic (crash flags, `move_strobe`).

Parameters:
- GRID_W, 64, grid width in cells (x range 0..GRID_W-1)
- GRID_H, 48, grid height in cells (y range 0..GRID_H-1)
- TICK_DIV, 1625000, clk cycles per move tick (65 MHz gives 40 moves/s); must be >= 2
- START_X1, 16, player 1 start x
- START_Y1, 24, player 1 start y
- START_X2, 47, player 2 start x
- START_Y2, 24, player 2 start y

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- game_active  in  1  level; 1 = play enabled, 0 = return to start
- direction_1  in  directions  player 1 heading (WAIT/RIGHT/DOWN/LEFT/UP)
- direction_2  in  directions  player 2 heading
- x1  out  XW=$clog2(GRID_W)  player 1 head x
- y1  out  YW=$clog2(GRID_H)  player 1 head y
- x2  out  XW  player 2 head x
- y2  out  YW  player 2 head y
- move_strobe  out  1  one-cycle pulse when positions were updated
- crash_1  out  1  latched, player 1 crashed
- crash_2  out  1  latched, player 2 crashed
- game_over  out  1  latched, any crash occurred

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; tick counter = 0.
  - x1/y1 = START_X1/START_Y1; x2/y2 = START_X2/START_Y2.
  - move_strobe = 0; crash_1 = 0; crash_2 = 0; game_over = 0.
- FSM states IDLE, RUN, OVER. All outputs are registered.
- IDLE:
  - Positions held at start values; counter held at 0; flags cleared.
  - game_active=1 → RUN on the next edge.
- RUN:
  - Counter increments each cycle, 0..TICK_DIV-1.
  - At TICK_DIV-1 (the tick), the counter wraps to 0 and the following are evaluated from the current positions and the directions sampled that cycle.
  - Candidate step:
    - RIGHT: x+1; LEFT: x-1; DOWN: y+1; UP: y-1.
    - WAIT: no move, and that player cannot crash itself.
  - Compute candidates at XW+1 / YW+1 bits, signed.
  - Wall crash: candidate < 0 or >= GRID_W/GRID_H. The crashing player's position holds.
  - Head-on: both players moving and both candidates equal → crash_1 = crash_2 = 1, both hold.
  - Contact: a moving player's candidate equals the other player's current position while that other player is in WAIT → the mover crashes and holds.
  - Non-crashing players take their candidate.
  - move_strobe = 1 for exactly the cycle after the tick, coincident with the new positions.
  - Any crash → crash flags and game_over set in that same update; state → OVER.
  - game_active=0 during RUN → IDLE next edge; positions return to start and the counter clears.
- OVER:
  - Positions, crash flags and game_over frozen; move_strobe = 0; counter held.
  - game_active=0 → IDLE.
- Directions are sampled only at the tick; changes between ticks are ignored, and the last value before the tick wins.
- Both players WAIT at a tick → move_strobe still pulses; positions unchanged.
- rst asserted mid-tick or in OVER → immediate return to reset values.

Optional Feature:
- Macro: PLAYER_POSITION_WRAP_EN.
- When defined:
  - Wall crashes are disabled.
  - x = -1 wraps to GRID_W-1 and x = GRID_W wraps to 0; same for y with GRID_H.
  - Head-on and contact rules still apply.
- When undefined: wall crash as specified above.

Decomposition:
- game_pkg (existing) holds `directions` plus the new items:
  - GRID_W_DEF / GRID_H_DEF constants
  - game_state_t enum (IDLE, RUN, OVER)
  - cell_pos_t struct {x, y}
- One sub-module, `move_tick_gen`: parameter TICK_DIV; inputs clk, rst, enable; output tick (one-cycle pulse); counter clears while enable=0.
- Step/crash evaluation stays inline as combinational logic.

Test Plan (TICK_DIV=4, GRID 8x6, starts (1,3) and (6,3)):
- Reset, then game_active=1, dir1=RIGHT, dir2=WAIT → first move_strobe 4 cycles after RUN entry; x1 increments 1→2→3 on successive strobes; x2 stays 6.
- dir1=UP from (1,3) for 4 ticks → y1 goes 2, 1, 0; 4th tick: crash_1=1, game_over=1, y1 stays 0, state OVER; no further strobes.
- Starts (3,3) and (5,3), dir1=RIGHT, dir2=LEFT → tick 1 both land on x=4?? No — candidates equal at (4,3) → crash_1 = crash_2 = 1, positions unchanged.
- Direction toggled RIGHT→DOWN→RIGHT between ticks → only the value at the tick cycle is used; single step right.
- In OVER, drop game_active → IDLE next cycle, positions back to (1,3)/(6,3), flags 0. Assert rst mid-RUN → all outputs at reset values within the same cycle (async).
- With PLAYER_POSITION_WRAP_EN: x1=7, dir1=RIGHT → next strobe x1=0, crash_1=0. y1=0, dir1=UP → y1=5.
